pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the pipeline and the PC sequencer.
// The sequencer uses the slave view; pipeline-side logic uses the master view.
interface pc_sequencer_if #(
  parameter int unsigned DW = 32
);
  logic [DW-1:0] PCCurrent;
  logic          BranchTaken;
  logic [DW-1:0] BranchTarget;
  logic          JumpEn;
  logic [DW-1:0] JumpTarget;
  logic          LoadUseHazard;
  logic          IMemReady;
  logic [DW-1:0] PCNext;
  logic          PCWrite;
  logic          PCReset;
  logic          IFIDWrite;
  logic          IFIDFlush;
  logic          IDEXFlush;
  logic [15:0]   StallCount;

  modport master (
    output PCCurrent, BranchTaken, BranchTarget, JumpEn, JumpTarget,
           LoadUseHazard, IMemReady,
    input  PCNext, PCWrite, PCReset, IFIDWrite, IFIDFlush, IDEXFlush,
           StallCount
  );

  modport slave (
    input  PCCurrent, BranchTaken, BranchTarget, JumpEn, JumpTarget,
           LoadUseHazard, IMemReady,
    output PCNext, PCWrite, PCReset, IFIDWrite, IFIDFlush, IDEXFlush,
           StallCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: chooses the next PC and the IF/ID and ID/EX control strobes
// from redirects, load-use hazards and instruction-memory readiness.
module pc_sequencer #(
  parameter int unsigned DW        = 32,
  parameter int unsigned STALL_CYC = 1
) (
  input logic           Clk,
  input logic           Reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    INIT,
    RUN,
    STALL,
    FLUSH,
    WAIT
  } state_t;

  localparam logic [3:0] STALL_LOAD = 4'(STALL_CYC - 1);

  state_t        state;
  state_t        state_next;
  logic [3:0]    stall_cnt;
  logic [3:0]    stall_cnt_next;
  logic          pend_valid;
  logic          pend_valid_next;
  logic [DW-1:0] pend_target;
  logic [DW-1:0] pend_target_next;
  logic [15:0]   stall_count;

  logic          redirect;
  logic [DW-1:0] target;
  logic [DW-1:0] pc_plus4;

  logic [DW-1:0] pc_next;
  logic          pc_write;
  logic          pc_reset;
  logic          ifid_write;
  logic          ifid_flush;
  logic          idex_flush;

  // Redirect resolution: a taken branch wins over a jump in the same cycle.
  always_comb begin
    redirect = bus.BranchTaken | bus.JumpEn;
    target   = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
    pc_plus4 = bus.PCCurrent + DW'(4);
  end

  // State, stall counter and pending-redirect registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= INIT;
      stall_cnt   <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_next;
      stall_cnt   <= stall_cnt_next;
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
    end
  end

  // Next-state and output decode; priority is redirect, hazard, memory wait.
  always_comb begin
    state_next       = state;
    stall_cnt_next   = stall_cnt;
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;
    pc_next          = pc_plus4;
    pc_write         = 1'b1;
    pc_reset         = 1'b0;
    ifid_write       = 1'b1;
    ifid_flush       = 1'b0;
    idex_flush       = 1'b0;

    case (state)
      INIT: begin
        pc_reset   = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b1;
        state_next = RUN;
      end

      WAIT: begin
        if (bus.IMemReady) begin
          pend_valid_next = 1'b0;
          if (redirect) begin
            pc_next    = target;
            idex_flush = bus.BranchTaken;
            state_next = FLUSH;
          end else if (pend_valid) begin
            pc_next    = pend_target;
            state_next = FLUSH;
          end else begin
            state_next = RUN;
          end
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ifid_flush = 1'b1;
          if (redirect) begin
            pend_valid_next  = 1'b1;
            pend_target_next = target;
            idex_flush       = bus.BranchTaken;
          end
        end
      end

      default: begin
        if (redirect) begin
          ifid_flush     = 1'b1;
          idex_flush     = bus.BranchTaken;
          stall_cnt_next = '0;
          if (bus.IMemReady) begin
            pc_next    = target;
            state_next = FLUSH;
          end else begin
            pc_write         = 1'b0;
            ifid_write       = 1'b0;
            pend_valid_next  = 1'b1;
            pend_target_next = target;
            state_next       = WAIT;
          end
        end else if (state == STALL) begin
          // A hazard seen while already stalling does not extend the stall.
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          if (stall_cnt <= 4'd1) begin
            stall_cnt_next = '0;
            state_next     = RUN;
          end else begin
            stall_cnt_next = stall_cnt - 4'd1;
          end
        end else if (bus.LoadUseHazard) begin
          pc_write       = 1'b0;
          ifid_write     = 1'b0;
          idex_flush     = 1'b1;
          stall_cnt_next = STALL_LOAD;
          state_next     = (STALL_LOAD == '0) ? RUN : STALL;
        end else if (!bus.IMemReady) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ifid_flush = 1'b1;
          state_next = WAIT;
        end else begin
          ifid_flush = (state == FLUSH);
          state_next = RUN;
        end
      end
    endcase
  end

  // Saturating count of cycles with the PC held, excluding the INIT cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_count <= '0;
    end else if ((state != INIT) && !pc_write && (stall_count != '1)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign bus.PCNext     = pc_next;
  assign bus.PCWrite    = pc_write;
  assign bus.PCReset    = pc_reset;
  assign bus.IFIDWrite  = ifid_write;
  assign bus.IFIDFlush  = ifid_flush;
  assign bus.IDEXFlush  = idex_flush;
  assign bus.StallCount = stall_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against a flag-based
// behavioural model of fetch control.
module tb_pc_sequencer;

  localparam int unsigned DW        = 32;
  localparam int unsigned STALL_CYC = 3;

  logic          clk;
  logic          rst;
  logic [DW-1:0] pc;
  logic          bt;
  logic [DW-1:0] btg;
  logic          je;
  logic [DW-1:0] jtg;
  logic          hz;
  logic          rdy;

  int n_vec;
  int n_err;

  pc_sequencer_if #(.DW(DW)) bus ();

  assign bus.PCCurrent     = pc;
  assign bus.BranchTaken   = bt;
  assign bus.BranchTarget  = btg;
  assign bus.JumpEn        = je;
  assign bus.JumpTarget    = jtg;
  assign bus.LoadUseHazard = hz;
  assign bus.IMemReady     = rdy;

  pc_sequencer #(.DW(DW), .STALL_CYC(STALL_CYC)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: flags and a remaining-stall count instead of a state machine.
  bit            m_init;
  bit            m_wait;
  bit            m_flush;
  bit            m_pv;
  logic [DW-1:0] m_pt;
  int            m_left;
  int            m_sc;

  logic [DW-1:0] e_next;
  bit            e_pcw, e_rst, e_ifw, e_iff, e_idf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_wait = 0; m_flush = 0; m_pv = 0; m_pt = '0; m_left = 0; m_sc = 0;
  endtask

  task automatic model_eval();
    bit redir;
    logic [DW-1:0] tgt;
    redir  = bt | je;
    tgt    = bt ? btg : jtg;
    e_next = pc + 32'd4;
    e_pcw = 1; e_rst = 0; e_ifw = 1; e_iff = 0; e_idf = 0;
    if (m_init) begin
      e_rst = 1; e_pcw = 0; e_ifw = 0; e_iff = 1;
    end else if (m_wait) begin
      if (rdy) begin
        if (redir) begin e_next = tgt; e_idf = bt; end
        else if (m_pv) e_next = m_pt;
      end else begin
        e_pcw = 0; e_ifw = 0; e_iff = 1;
        if (redir) e_idf = bt;
      end
    end else if (redir) begin
      e_iff = 1; e_idf = bt;
      if (rdy) e_next = tgt;
      else begin e_pcw = 0; e_ifw = 0; end
    end else if (m_left > 0 || hz) begin
      e_pcw = 0; e_ifw = 0; e_idf = 1;
    end else if (!rdy) begin
      e_pcw = 0; e_ifw = 0; e_iff = 1;
    end else if (m_flush) begin
      e_iff = 1;
    end
  endtask

  task automatic model_step();
    bit redir;
    logic [DW-1:0] tgt;
    redir = bt | je;
    tgt   = bt ? btg : jtg;
    if (!m_init && !e_pcw && m_sc < 65535) m_sc++;
    if (m_init) begin
      m_init = 0;
    end else if (m_wait) begin
      if (rdy) begin m_flush = redir || m_pv; m_wait = 0; m_pv = 0; end
      else if (redir) begin m_pv = 1; m_pt = tgt; end
    end else if (redir) begin
      m_left = 0;
      if (rdy) m_flush = 1;
      else begin m_wait = 1; m_pv = 1; m_pt = tgt; m_flush = 0; end
    end else if (m_left > 0) begin
      m_left--; m_flush = 0;
    end else if (hz) begin
      m_left = STALL_CYC - 1; m_flush = 0;
    end else if (!rdy) begin
      m_wait = 1; m_flush = 0;
    end else begin
      m_flush = 0;
    end
  endtask

  task automatic check_outputs();
    check("PCNext",     64'(bus.PCNext),     64'(e_next));
    check("PCWrite",    64'(bus.PCWrite),    64'(e_pcw));
    check("PCReset",    64'(bus.PCReset),    64'(e_rst));
    check("IFIDWrite",  64'(bus.IFIDWrite),  64'(e_ifw));
    check("IFIDFlush",  64'(bus.IFIDFlush),  64'(e_iff));
    check("IDEXFlush",  64'(bus.IDEXFlush),  64'(e_idf));
    check("StallCount", 64'(bus.StallCount), 64'(m_sc));
  endtask

  // Called just after a rising edge: apply inputs, check mid-cycle, advance.
  task automatic cycle(input logic [DW-1:0] i_pc, input bit i_bt, input logic [DW-1:0] i_btg,
                       input bit i_je, input logic [DW-1:0] i_jtg, input bit i_hz, input bit i_rdy);
    pc = i_pc; bt = i_bt; btg = i_btg; je = i_je; jtg = i_jtg; hz = i_hz; rdy = i_rdy;
    @(negedge clk);
    model_eval();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset in mid-cycle; outputs must change before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    model_eval();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    pc = '0; bt = 0; btg = '0; je = 0; jtg = '0; hz = 0; rdy = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    model_eval();
    check_outputs();
    rst = 1'b0;

    // Release from reset: one INIT cycle, then sequential fetch.
    repeat (3) cycle(32'h0, 0, '0, 0, '0, 0, 1);
    // Simultaneous branch and jump: branch wins, then one flush cycle.
    cycle(32'h40, 1, 32'h100, 1, 32'h200, 0, 1);
    cycle(32'h100, 0, '0, 0, '0, 0, 1);
    cycle(32'h104, 0, '0, 0, '0, 0, 1);
    // Load-use pulse gives a three-cycle stall.
    cycle(32'h108, 0, '0, 0, '0, 1, 1);
    repeat (3) cycle(32'h108, 0, '0, 0, '0, 0, 1);
    // Memory not ready for four cycles with a jump seen in the second.
    cycle(32'h10c, 0, '0, 0, '0, 0, 0);
    cycle(32'h10c, 0, '0, 1, 32'h80, 0, 0);
    repeat (2) cycle(32'h10c, 0, '0, 0, '0, 0, 0);
    cycle(32'h10c, 0, '0, 0, '0, 0, 1);
    cycle(32'h80, 0, '0, 0, '0, 0, 1);
    cycle(32'h84, 0, '0, 0, '0, 0, 1);
    // Branch in the middle of a stall aborts it.
    cycle(32'h88, 0, '0, 0, '0, 1, 1);
    cycle(32'h88, 1, 32'h300, 0, '0, 0, 1);
    cycle(32'h300, 0, '0, 0, '0, 0, 1);
    cycle(32'h304, 0, '0, 0, '0, 0, 1);
    // Reset while waiting with a pending redirect discards it.
    cycle(32'h308, 0, '0, 0, '0, 0, 0);
    cycle(32'h308, 0, '0, 1, 32'h500, 0, 0);
    do_reset();
    repeat (3) cycle(32'h0, 0, '0, 0, '0, 0, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle($urandom(),
              ($urandom_range(0, 9) == 0), $urandom(),
              ($urandom_range(0, 9) == 0), $urandom(),
              ($urandom_range(0, 6) == 0),
              ($urandom_range(0, 4) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
